// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one word-addressed bus transfer per
// load/store, stalls the pipeline while it is outstanding, returns aligned and
// extended load data, and flags misaligned accesses and bus timeouts.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memenM,
   input  logic [2:0]  lsopM,
   input  logic [31:0] aluoutM,
   input  logic [31:0] writedataM,
   output logic [31:0] readdataM,
   output logic        stallM,
   output logic        adelM,
   output logic        adesM,
   output logic        buserrM,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 4;
   localparam int unsigned CW = 8;

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LBU = 3'b001;
   localparam logic [2:0] OP_LH  = 3'b010;
   localparam logic [2:0] OP_LHU = 3'b011;
   localparam logic [2:0] OP_LW  = 3'b100;
   localparam logic [2:0] OP_SB  = 3'b101;
   localparam logic [2:0] OP_SH  = 3'b110;
   localparam logic [2:0] OP_SW  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;

   logic [2:0]      r_lsop;
   logic [1:0]      r_alo;
   logic [CW-1:0]   r_cnt;
   logic [DW-1:0]   r_rdata;
   logic            r_err;
   logic [AW-1:0]   r_mem_addr;
   logic            r_mem_wr;
   logic [BW-1:0]   r_mem_wstrb;
   logic [DW-1:0]   r_mem_wdata;

   logic            w_is_store;
   logic            w_misaligned;
   logic            w_idle;
   logic            w_issue;
   logic            w_timeout;
   logic [BW-1:0]   w_wstrb;
   logic [DW-1:0]   w_wdata;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [DW-1:0]   w_load_data;

   assign w_is_store = lsopM[2] & (lsopM[1:0] != 2'b00);
   assign w_idle     = (r_state == S_IDLE);
   assign w_issue    = w_idle & memenM & ~w_misaligned;
   assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));

   assign adelM = w_idle & memenM & w_misaligned & ~w_is_store;
   assign adesM = w_idle & memenM & w_misaligned &  w_is_store;

   assign mem_addr  = r_mem_addr;
   assign mem_wr    = r_mem_wr;
   assign mem_wstrb = r_mem_wstrb;
   assign mem_wdata = r_mem_wdata;

   // Alignment check on the incoming opcode and low address bits
   always_comb begin
      w_misaligned = 1'b0;
      case (lsopM)
         OP_LH, OP_LHU, OP_SH: w_misaligned = aluoutM[0];
         OP_LW, OP_SW:         w_misaligned = |aluoutM[1:0];
         default:              w_misaligned = 1'b0;
      endcase
   end

   // Store byte strobes and lane-replicated write data
   always_comb begin
      w_wstrb = '0;
      w_wdata = writedataM;
      case (lsopM)
         OP_SB: begin
            w_wstrb = BW'(4'b0001 << aluoutM[1:0]);
            w_wdata = {4{writedataM[7:0]}};
         end
         OP_SH: begin
            w_wstrb = aluoutM[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{writedataM[15:0]}};
         end
         OP_SW: begin
            w_wstrb = 4'b1111;
            w_wdata = writedataM;
         end
         default: begin
            w_wstrb = '0;
            w_wdata = writedataM;
         end
      endcase
   end

   // Extract and extend the addressed byte/half/word of the returned beat
   always_comb begin
      w_byte      = mem_rdata[{r_alo, 3'b000} +: 8];
      w_half      = mem_rdata[{r_alo[1], 4'b0000} +: 16];
      w_load_data = '0;
      case (r_lsop)
         OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  w_load_data = {24'd0, w_byte};
         OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
         OP_LHU:  w_load_data = {16'd0, w_half};
         OP_LW:   w_load_data = mem_rdata;
         default: w_load_data = '0;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_issue) w_next = S_REQ;
         S_REQ:  if (mem_ready || w_timeout) w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State-decoded outputs; result and error are visible only in DONE
   always_comb begin
      stallM    = 1'b0;
      mem_req   = 1'b0;
      readdataM = '0;
      buserrM   = 1'b0;
      case (r_state)
         S_IDLE: stallM = memenM & ~w_misaligned;
         S_REQ: begin
            stallM  = 1'b1;
            mem_req = 1'b1;
         end
         S_DONE: begin
            readdataM = r_rdata;
            buserrM   = r_err;
         end
         default: begin
            stallM = 1'b0;
         end
      endcase
   end

   // Transfer context latch, timeout counter and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lsop      <= '0;
         r_alo       <= '0;
         r_cnt       <= '0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wr    <= 1'b0;
         r_mem_wstrb <= '0;
         r_mem_wdata <= '0;
      end else if (r_state == S_IDLE) begin
         if (w_issue) begin
            r_lsop      <= lsopM;
            r_alo       <= aluoutM[1:0];
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_mem_addr  <= {aluoutM[AW-1:2], 2'b00};
            r_mem_wr    <= w_is_store;
            r_mem_wstrb <= w_wstrb;
            r_mem_wdata <= w_wdata;
         end
      end else if (r_state == S_REQ) begin
         if (mem_ready) begin
            r_rdata <= w_load_data;
            r_err   <= 1'b0;
         end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end else begin
         r_rdata <= '0;
         r_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (instantiated with TIMEOUT=4).
module tb_mem_access_unit;

   localparam logic [2:0] LB = 3'b000, LBU = 3'b001, LH = 3'b010, LHU = 3'b011;
   localparam logic [2:0] LW = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

   logic        clk;
   logic        rst;
   logic        memenM;
   logic [2:0]  lsopM;
   logic [31:0] aluoutM;
   logic [31:0] writedataM;
   logic [31:0] readdataM;
   logic        stallM;
   logic        adelM;
   logic        adesM;
   logic        buserrM;
   logic        mem_req;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   int n_cmp;
   int n_fail;
   logic [31:0] exp_q[$];

   typedef struct {
      int          stalls;
      int          reqs;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic        wr;
      logic        stable;
      logic [31:0] rd;
      logic        err;
      logic        done;
   } obs_t;

   mem_access_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .memenM(memenM), .lsopM(lsopM), .aluoutM(aluoutM),
      .writedataM(writedataM), .readdataM(readdataM), .stallM(stallM),
      .adelM(adelM), .adesM(adesM), .buserrM(buserrM), .mem_req(mem_req),
      .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference models
   function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] rd);
      logic [31:0] sb, sh;
      sb = rd >> (8 * int'(a[1:0]));
      sh = rd >> (16 * int'(a[1]));
      case (op)
         LB:      return {{24{sb[7]}}, sb[7:0]};
         LBU:     return {24'h0, sb[7:0]};
         LH:      return {{16{sh[15]}}, sh[15:0]};
         LHU:     return {16'h0, sh[15:0]};
         LW:      return rd;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [3:0] exp_strb(input logic [2:0] op, input logic [31:0] a);
      case (op)
         SB:      return 4'b0001 << a[1:0];
         SH:      return a[1] ? 4'b1100 : 4'b0011;
         SW:      return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] wd);
      case (op)
         SB:      return {4{wd[7:0]}};
         SH:      return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   // Drives one aligned access; called and returns at posedge+1.
   // mem_ready is raised in REQ cycle number wait_n+1.
   task automatic run_txn(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdata,
                          input int wait_n, output obs_t o);
      o.stalls = 0; o.reqs = 0; o.addr = '0; o.strb = '0; o.wdata = '0;
      o.wr = 1'b0; o.stable = 1'b1; o.rd = '0; o.err = 1'b0; o.done = 1'b0;
      memenM = 1'b1; lsopM = op; aluoutM = addr; writedataM = wd;
      mem_rdata = rdata; mem_ready = 1'b0;
      for (int cyc = 0; cyc < 300 && !o.done; cyc++) begin
         @(negedge clk);
         if (stallM) o.stalls++;
         if (mem_req) begin
            o.reqs++;
            if (o.reqs == 1) begin
               o.addr = mem_addr; o.strb = mem_wstrb; o.wdata = mem_wdata; o.wr = mem_wr;
            end else if (mem_addr !== o.addr || mem_wstrb !== o.strb ||
                         mem_wdata !== o.wdata || mem_wr !== o.wr) begin
               o.stable = 1'b0;
            end
            mem_ready = (o.reqs == wait_n + 1);
         end else if (o.reqs > 0) begin
            o.rd = readdataM; o.err = buserrM; o.done = 1'b1;
            mem_ready = 1'b0;
         end
         if (!o.done) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      memenM = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if ({readdataM, stallM, buserrM, mem_req, mem_wr, mem_addr, mem_wstrb, mem_wdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: rd=%h stall=%b err=%b req=%b wr=%b addr=%h strb=%b wdata=%h, need all 0",
                  readdataM, stallM, buserrM, mem_req, mem_wr, mem_addr, mem_wstrb, mem_wdata);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (stallM !== 1'b0 || mem_req !== 1'b0 || readdataM !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_release: stall=%b req=%b rd=%h, need 0/0/0", stallM, mem_req, readdataM);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_load_byte();
      obs_t o;
      logic [31:0] e;
      exp_q.push_back(32'hFFFF_FF80);
      run_txn(LB, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 0, o);
      e = exp_q.pop_front();
      n_cmp++;
      if (o.done !== 1'b1 || o.rd !== e) begin
         n_fail++; $display("FAIL lb_data: done=%b got %h, need %h", o.done, o.rd, e);
      end
      n_cmp++;
      if (o.stalls !== 2) begin
         n_fail++; $display("FAIL lb_stalls: got %0d, need 2", o.stalls);
      end
      n_cmp++;
      if (o.addr !== 32'h0000_1000 || o.wr !== 1'b0 || o.strb !== 4'b0000) begin
         n_fail++; $display("FAIL lb_bus: addr=%h wr=%b strb=%b, need 00001000/0/0000", o.addr, o.wr, o.strb);
      end
      exp_q.push_back(32'h0000_0080);
      run_txn(LBU, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 0, o);
      e = exp_q.pop_front();
      n_cmp++;
      if (o.done !== 1'b1 || o.rd !== e) begin
         n_fail++; $display("FAIL lbu_data: done=%b got %h, need %h", o.done, o.rd, e);
      end
   endtask

   task automatic test_store_half();
      obs_t o;
      logic [31:0] e;
      exp_q.push_back(32'h0);
      run_txn(SH, 32'h0000_2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 3, o);
      e = exp_q.pop_front();
      n_cmp++;
      if (o.reqs !== 4 || o.stalls !== 5) begin
         n_fail++; $display("FAIL sh_cycles: req=%0d stall=%0d, need 4/5", o.reqs, o.stalls);
      end
      n_cmp++;
      if (o.wr !== 1'b1 || o.strb !== 4'b1100 || o.wdata !== 32'hABCD_ABCD || o.addr !== 32'h0000_2000) begin
         n_fail++;
         $display("FAIL sh_bus: wr=%b strb=%b wdata=%h addr=%h, need 1/1100/abcdabcd/00002000",
                  o.wr, o.strb, o.wdata, o.addr);
      end
      n_cmp++;
      if (o.stable !== 1'b1) begin
         n_fail++; $display("FAIL sh_stable: bus changed during wait, stable=%b need 1", o.stable);
      end
      n_cmp++;
      if (o.done !== 1'b1 || o.rd !== e || o.err !== 1'b0) begin
         n_fail++; $display("FAIL sh_result: done=%b rd=%h err=%b, need 1/%h/0", o.done, o.rd, o.err, e);
      end
   endtask

   task automatic test_misaligned();
      logic [2:0]  ops[3]  = '{LW, SW, LH};
      logic [31:0] adrs[3] = '{32'h3001, 32'h3002, 32'h4001};
      logic        st[3]   = '{1'b0, 1'b1, 1'b0};
      logic        seen;
      for (int i = 0; i < 3; i++) begin
         memenM = 1'b1; lsopM = ops[i]; aluoutM = adrs[i]; writedataM = 32'h5555_AAAA;
         @(negedge clk);
         n_cmp++;
         if (adelM !== !st[i] || adesM !== st[i] || stallM !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_flags[%0d]: adel=%b ades=%b stall=%b, need %b/%b/0",
                     i, adelM, adesM, stallM, !st[i], st[i]);
         end
         seen = 1'b0;
         for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (mem_req !== 1'b0 || readdataM !== 32'h0) seen = 1'b1;
         end
         n_cmp++;
         if (seen !== 1'b0) begin
            n_fail++; $display("FAIL misalign_noreq[%0d]: request/data seen=%b, need 0", i, seen);
         end
         memenM = 1'b0;
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_cmp++;
      if (adelM !== 1'b0 || adesM !== 1'b0) begin
         n_fail++; $display("FAIL misalign_idle: adel=%b ades=%b with memen=0, need 0/0", adelM, adesM);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_timeout();
      obs_t o;
      logic [31:0] e;
      exp_q.push_back(32'h0);
      run_txn(LH, 32'h0000_4000, 32'h0, 32'h1234_5678, 1000, o);
      e = exp_q.pop_front();
      n_cmp++;
      if (o.done !== 1'b1 || o.reqs !== 4) begin
         n_fail++; $display("FAIL to_reqs: done=%b req=%0d, need 1/4", o.done, o.reqs);
      end
      n_cmp++;
      if (o.err !== 1'b1 || o.rd !== e) begin
         n_fail++; $display("FAIL to_result: err=%b rd=%h, need 1/%h", o.err, o.rd, e);
      end
      @(negedge clk);
      n_cmp++;
      if (buserrM !== 1'b0 || stallM !== 1'b0 || mem_req !== 1'b0) begin
         n_fail++; $display("FAIL to_after: err=%b stall=%b req=%b, need 0/0/0", buserrM, stallM, mem_req);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      obs_t o1, o2;
      logic [31:0] e;
      exp_q.push_back(32'hDEAD_BEEF);
      run_txn(LW, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, o1);
      exp_q.push_back(32'h0);
      run_txn(SB, 32'h0000_0015, 32'h0000_00A5, 32'h0, 0, o2);
      e = exp_q.pop_front();
      n_cmp++;
      if (o1.done !== 1'b1 || o1.rd !== e) begin
         n_fail++; $display("FAIL b2b_lw: done=%b rd=%h, need 1/%h", o1.done, o1.rd, e);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (o2.addr !== 32'h0000_0014 || o2.wr !== 1'b1 || o2.reqs !== 1 || o2.stalls !== 2) begin
         n_fail++;
         $display("FAIL b2b_issue: addr=%h wr=%b req=%0d stall=%0d, need 00000014/1/1/2",
                  o2.addr, o2.wr, o2.reqs, o2.stalls);
      end
      n_cmp++;
      if (o2.strb !== 4'b0010 || o2.wdata !== 32'hA5A5_A5A5 || o2.rd !== e) begin
         n_fail++; $display("FAIL b2b_sb: strb=%b wdata=%h rd=%h, need 0010/a5a5a5a5/%h",
                            o2.strb, o2.wdata, o2.rd, e);
      end
   endtask

   task automatic test_reset_midflight();
      obs_t o;
      logic [31:0] e;
      memenM = 1'b1; lsopM = LW; aluoutM = 32'h0000_0040; writedataM = 32'h0;
      mem_rdata = 32'h1111_2222; mem_ready = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_req: req=%b, need 1", mem_req);
      end
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b1; memenM = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b0 || stallM !== 1'b0 || mem_addr !== 32'h0 ||
          mem_wstrb !== 4'b0 || readdataM !== 32'h0 || buserrM !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_clear: req=%b stall=%b addr=%h strb=%b rd=%h err=%b, need all 0",
                  mem_req, stallM, mem_addr, mem_wstrb, readdataM, buserrM);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      exp_q.push_back(32'hCAFE_F00D);
      run_txn(LW, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 1, o);
      e = exp_q.pop_front();
      n_cmp++;
      if (o.done !== 1'b1 || o.rd !== e || o.stalls !== 3 || o.addr !== 32'h0000_0020) begin
         n_fail++; $display("FAIL rstmid_lw: done=%b rd=%h stall=%0d addr=%h, need 1/%h/3/00000020",
                            o.done, o.rd, o.stalls, o.addr, e);
      end
   endtask

   task automatic test_random();
      obs_t o;
      logic [2:0]  op;
      logic [31:0] a, wd, rd, e;
      for (int i = 0; i < 12; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom; wd = $urandom; rd = $urandom;
         if (op == LH || op == LHU || op == SH) a[0] = 1'b0;
         if (op == LW || op == SW) a[1:0] = 2'b00;
         exp_q.push_back(exp_load(op, a, rd));
         run_txn(op, a, wd, rd, int'($urandom_range(0, 2)), o);
         e = exp_q.pop_front();
         n_cmp++;
         if (o.done !== 1'b1 || o.rd !== e || o.err !== 1'b0) begin
            n_fail++; $display("FAIL rand_rd[%0d] op=%0d a=%h: done=%b rd=%h err=%b, need 1/%h/0",
                               i, op, a, o.done, o.rd, o.err, e);
         end
         n_cmp++;
         if (o.addr !== {a[31:2], 2'b00} || o.strb !== exp_strb(op, a) ||
             o.wr !== (op >= SB) || (op >= SB && o.wdata !== exp_wdata(op, wd))) begin
            n_fail++; $display("FAIL rand_bus[%0d] op=%0d: addr=%h strb=%b wr=%b wdata=%h, need %h/%b/%b/%h",
                               i, op, o.addr, o.strb, o.wr, o.wdata, {a[31:2], 2'b00},
                               exp_strb(op, a), (op >= SB), exp_wdata(op, wd));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_fail = 0;
      rst = 1'b1; memenM = 1'b0; lsopM = '0; aluoutM = '0; writedataM = '0;
      mem_rdata = '0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_load_byte();
      test_store_half();
      test_misaligned();
      test_timeout();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
